// File: rtl/sr_arb_pkg.sv
// Shared definitions for the SR flag arbiter: FSM state encoding and the
// helper that extracts one requester's flag-index field from a packed vector.
package sr_arb_pkg;

  // Widest packed index vector the slice helper accepts (NREQ*FLAG_W must fit).
  localparam int IDX_PAD_W = 256;

  // FSM encoding; the unused code 2'd3 is steered back to IDLE by the FSM.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Return field number `sel` (each `w` bits wide) of a packed vector.
  function automatic logic [31:0] idx_slice(
    input logic [IDX_PAD_W-1:0] vec,
    input int unsigned          sel,
    input int unsigned          w
  );
    logic [IDX_PAD_W-1:0] sh;
    logic [31:0]          mask;
    sh   = vec >> (sel * w);
    mask = (32'd1 << w) - 32'd1;
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps,
// returning a one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            valid_o
);

  int          cand_s;
  logic [IW-1:0] cand_idx_s;

  // First requester at or after the pointer (modulo NREQ) wins.
  always_comb begin
    gnt_o      = {NREQ{1'b0}};
    gnt_idx_o  = {IW{1'b0}};
    valid_o    = 1'b0;
    cand_s     = 0;
    cand_idx_s = {IW{1'b0}};
    for (int off = 0; off < NREQ; off++) begin
      cand_s = int'(ptr_i) + off;
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = IW'(cand_s);
      if (!valid_o && req_i[cand_idx_s]) begin
        valid_o            = 1'b1;
        gnt_idx_o          = cand_idx_s;
        gnt_o[cand_idx_s]  = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin serialiser of set/clear commands from NREQ requesters onto a
// bank of NFLAG SR flags. Set dominates clear; out-of-range indices are acked
// with err_o and leave the bank untouched.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int NFLAG  = 8,
  localparam int FLAG_W = $clog2(NFLAG),
  localparam int GW     = $clog2(NREQ)
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          set_i,
  input  logic [NREQ-1:0]          clr_i,
  input  logic [NREQ*FLAG_W-1:0]   idx_i,
  output logic [NREQ-1:0]          ack_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [GW-1:0]            grant_id,
  output logic [NFLAG-1:0]         Q,
  output logic [NFLAG-1:0]         Qbar
);

  arb_state_e          state_q;
  logic [NFLAG-1:0]    q_q, qbar_q, q_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                err_q, busy_q;
  logic [GW-1:0]       grant_q, ptr_q, ptr_d;
  logic                lat_set_q, lat_clr_q, lat_bad_q;
  logic [FLAG_W-1:0]   lat_idx_q;

  logic [NREQ-1:0]     arb_gnt_s;
  logic [GW-1:0]       arb_idx_s;
  logic                arb_valid_s;
  logic [IDX_PAD_W-1:0] idx_pad_s;
  logic [31:0]         win_idx_s;
  logic                win_set_s, win_clr_s, win_bad_s;
  logic [NFLAG-1:0]    sel_s;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt_s),
    .gnt_idx_o (arb_idx_s),
    .valid_o   (arb_valid_s)
  );

  // Pick out the winner's command and the pointer value that follows it.
  always_comb begin
    idx_pad_s                   = {IDX_PAD_W{1'b0}};
    idx_pad_s[NREQ*FLAG_W-1:0]  = idx_i;
    win_idx_s = idx_slice(idx_pad_s, 32'(arb_idx_s), 32'(FLAG_W));
    win_set_s = |(set_i & arb_gnt_s);
    win_clr_s = |(clr_i & arb_gnt_s);
    win_bad_s = (win_idx_s >= 32'(NFLAG));
    if (arb_idx_s == GW'(NREQ - 1)) begin
      ptr_d = {GW{1'b0}};
    end else begin
      ptr_d = arb_idx_s + GW'(1);
    end
  end

  // Next flag-bank value and ack vector for the latched command; an
  // out-of-range index decodes to an empty select and so changes nothing.
  always_comb begin
    sel_s = {NFLAG{1'b0}};
    for (int k = 0; k < NFLAG; k++) begin
      sel_s[k] = (lat_idx_q == FLAG_W'(k)) && !lat_bad_q;
    end
    if (lat_set_q) begin
      q_d = q_q | sel_s;
    end else if (lat_clr_q) begin
      q_d = q_q & ~sel_s;
    end else begin
      q_d = q_q;
    end
    ack_d = {NREQ{1'b0}};
    for (int r = 0; r < NREQ; r++) begin
      ack_d[r] = (grant_q == GW'(r));
    end
  end

  // Control FSM, command latch, pointer and flag bank; reset aborts any op.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      q_q       <= {NFLAG{1'b0}};
      qbar_q    <= {NFLAG{1'b1}};
      ack_q     <= {NREQ{1'b0}};
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      grant_q   <= {GW{1'b0}};
      ptr_q     <= {GW{1'b0}};
      lat_set_q <= 1'b0;
      lat_clr_q <= 1'b0;
      lat_bad_q <= 1'b0;
      lat_idx_q <= {FLAG_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= {NREQ{1'b0}};
          err_q <= 1'b0;
          if (arb_valid_s) begin
            lat_set_q <= win_set_s;
            lat_clr_q <= win_clr_s;
            lat_bad_q <= win_bad_s;
            lat_idx_q <= FLAG_W'(win_idx_s);
            grant_q   <= arb_idx_s;
            ptr_q     <= ptr_d;
            busy_q    <= 1'b1;
            state_q   <= APPLY;
          end else begin
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        APPLY: begin
          q_q     <= q_d;
          qbar_q  <= ~q_d;
          ack_q   <= ack_d;
          err_q   <= lat_bad_q;
          busy_q  <= 1'b1;
          state_q <= RELEASE;
        end
        RELEASE: begin
          ack_q   <= {NREQ{1'b0}};
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= {NREQ{1'b0}};
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;
  assign grant_id = grant_q;
  assign Q        = q_q;
  assign Qbar     = qbar_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: an 8-flag instance for the main
// behaviour and a 6-flag instance for out-of-range index handling.
module tb_sr_flag_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req8, set8, clr8, ack8;
  logic [11:0] idx8;
  logic        err8, busy8;
  logic [1:0]  gid8;
  logic [7:0]  q8, qb8;

  logic [3:0]  req6, set6, clr6, ack6;
  logic [11:0] idx6;
  logic        err6, busy6;
  logic [1:0]  gid6;
  logic [5:0]  q6, qb6;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) u_dut8 (
    .CLK(clk), .rst(rst), .req(req8), .set_i(set8), .clr_i(clr8), .idx_i(idx8),
    .ack_o(ack8), .err_o(err8), .busy_o(busy8), .grant_id(gid8), .Q(q8), .Qbar(qb8)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6)) u_dut6 (
    .CLK(clk), .rst(rst), .req(req6), .set_i(set6), .clr_i(clr6), .idx_i(idx6),
    .ack_o(ack6), .err_o(err6), .busy_o(busy6), .grant_id(gid6), .Q(q6), .Qbar(qb6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req8 = 4'd0; set8 = 4'd0; clr8 = 4'd0; idx8 = 12'd0;
    req6 = 4'd0; set6 = 4'd0; clr6 = 4'd0; idx6 = 12'd0;
    #2;

    // 1 reset with random requests
    rst = 1'b1; req8 = 4'($urandom); req6 = 4'($urandom);
    set8 = 4'($urandom); clr8 = 4'($urandom);
    step(); step();
    check_val("rst_q", 32'(q8), 32'h00);
    check_val("rst_qbar", 32'(qb8), 32'hFF);
    check_val("rst_ack", 32'(ack8), 32'h0);
    check_val("rst_busy", 32'(busy8), 32'h0);
    check_val("rst_gid", 32'(gid8), 32'h0);
    check_val("rst_err", 32'(err8), 32'h0);
    check_val("rst_q6", 32'(q6), 32'h00);
    check_val("rst_qbar6", 32'(qb6), 32'h3F);
    rst = 1'b0; req8 = 4'd0; req6 = 4'd0; set8 = 4'd0; clr8 = 4'd0;

    // 5 bad index on the 6-flag instance
    req6 = 4'b0001; set6 = 4'b0001; idx6 = 12'h004;
    step(); step();
    check_val("b_ok_q", 32'(q6), 32'h10);
    check_val("b_ok_qbar", 32'(qb6), 32'h2F);
    check_val("b_ok_ack", 32'(ack6), 32'h1);
    check_val("b_ok_err", 32'(err6), 32'h0);
    req6 = 4'd0;
    step();
    check_val("b_ok_ackdrop", 32'(ack6), 32'h0);
    req6 = 4'b0010; set6 = 4'b0010; idx6 = 12'h038;
    step();
    check_val("b7_gid", 32'(gid6), 32'h1);
    check_val("b7_busy", 32'(busy6), 32'h1);
    step();
    check_val("b7_q", 32'(q6), 32'h10);
    check_val("b7_err", 32'(err6), 32'h1);
    check_val("b7_ack", 32'(ack6), 32'h2);
    req6 = 4'd0;
    step();
    check_val("b7_errdrop", 32'(err6), 32'h0);
    check_val("b7_ackdrop", 32'(ack6), 32'h0);
    req6 = 4'b0100; set6 = 4'b0100; idx6 = 12'h180;
    step(); step();
    check_val("b6_q", 32'(q6), 32'h10);
    check_val("b6_err", 32'(err6), 32'h1);
    check_val("b6_ack", 32'(ack6), 32'h4);
    req6 = 4'd0;
    step();

    // 2 single set then clear
    req8 = 4'b0010; set8 = 4'b0010; clr8 = 4'b0000; idx8 = 12'h018;
    step();
    check_val("s_gid", 32'(gid8), 32'h1);
    check_val("s_busy", 32'(busy8), 32'h1);
    check_val("s_q_early", 32'(q8), 32'h00);
    check_val("s_ack_early", 32'(ack8), 32'h0);
    step();
    check_val("s_q", 32'(q8), 32'h08);
    check_val("s_qbar", 32'(qb8), 32'hF7);
    check_val("s_ack", 32'(ack8), 32'h2);
    req8 = 4'd0;
    step();
    check_val("s_ackdrop", 32'(ack8), 32'h0);
    check_val("s_idle", 32'(busy8), 32'h0);
    req8 = 4'b0010; set8 = 4'b0000; clr8 = 4'b0010; idx8 = 12'h018;
    step(); step();
    check_val("c_q", 32'(q8), 32'h00);
    check_val("c_ack", 32'(ack8), 32'h2);
    req8 = 4'd0;
    step();

    // 3 set dominance and no-op
    req8 = 4'b0100; set8 = 4'b0100; clr8 = 4'b0100; idx8 = 12'h140;
    step(); step();
    check_val("d_q", 32'(q8), 32'h20);
    check_val("d_ack", 32'(ack8), 32'h4);
    req8 = 4'd0;
    step();
    req8 = 4'b0100; set8 = 4'b0000; clr8 = 4'b0000; idx8 = 12'h140;
    step(); step();
    check_val("n_q", 32'(q8), 32'h20);
    check_val("n_ack", 32'(ack8), 32'h4);
    check_val("n_err", 32'(err8), 32'h0);
    req8 = 4'd0;
    step();

    // 4 round-robin from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    req8 = 4'b1111; set8 = 4'b1111; clr8 = 4'b0000; idx8 = 12'h688;
    exp_q = 8'h00;
    for (int k = 0; k < 5; k++) begin
      step();
      check_val($sformatf("rr_gid%0d", k), 32'(gid8), 32'(k % 4));
      step();
      exp_q = exp_q | (8'h01 << (k % 4));
      check_val($sformatf("rr_ack%0d", k), 32'(ack8), 32'(4'b0001 << (k % 4)));
      check_val($sformatf("rr_q%0d", k), 32'(q8), 32'(exp_q));
      step();
      check_val($sformatf("rr_ackdrop%0d", k), 32'(ack8), 32'h0);
    end
    check_val("rr_qfinal", 32'(q8), 32'h0F);
    req8 = 4'd0;
    step();

    // 6 reset during APPLY, then re-arbitration from pointer 0
    req8 = 4'b1001; set8 = 4'b1001; clr8 = 4'b0000; idx8 = 12'h406;
    step();
    check_val("m_gid", 32'(gid8), 32'h3);
    rst = 1'b1;
    step();
    check_val("m_q", 32'(q8), 32'h00);
    check_val("m_ack", 32'(ack8), 32'h0);
    check_val("m_busy", 32'(busy8), 32'h0);
    check_val("m_gid_rst", 32'(gid8), 32'h0);
    rst = 1'b0;
    step();
    check_val("m_regid", 32'(gid8), 32'h0);
    check_val("m_rebusy", 32'(busy8), 32'h1);
    step();
    check_val("m_req", 32'(q8), 32'h40);
    check_val("m_reack", 32'(ack8), 32'h1);
    req8 = 4'd0;
    step();
    check_val("m_ackdrop", 32'(ack8), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
